// File: rtl/mv_job_sched_if.sv
// Host-side channels of the job scheduler: descriptor push and status-record return.
interface mv_job_sched_if #(
    parameter int WIDTH_W = 9,
    parameter int ITER_W  = 16,
    parameter int TAG_W   = 4,
    parameter int CNT_W   = 32
);
    logic               job_valid;
    logic               job_ready;
    logic [WIDTH_W-1:0] job_width;
    logic [ITER_W-1:0]  job_iter;
    logic [TAG_W-1:0]   job_tag;

    logic               done_valid;
    logic               done_ready;
    logic [TAG_W-1:0]   done_tag;
    logic [1:0]         done_status;
    logic               done_bank;
    logic [CNT_W-1:0]   done_cycles;

    modport master (
        output job_valid, job_width, job_iter, job_tag, done_ready,
        input  job_ready, done_valid, done_tag, done_status, done_bank, done_cycles
    );

    modport slave (
        input  job_valid, job_width, job_iter, job_tag, done_ready,
        output job_ready, done_valid, done_tag, done_status, done_bank, done_cycles
    );
endinterface

// File: rtl/mv_job_sched.sv
// Queues matrix-vector job descriptors and runs them one at a time on the Controller,
// returning one status record (tag, status, bank, cycle count) per launched or rejected job.
//
// state  | meaning
// IDLE   | pop head (first cycle), then launch or reject it (second cycle)
// RUN    | ctrl_running high, watching finish / timeout / abort
// REPORT | status record held until consumed
// GAP    | enforced ctrl_running low time before the next launch
module mv_job_sched #(
    parameter int WIDTH_W        = 9,
    parameter int ITER_W         = 16,
    parameter int TAG_W          = 4,
    parameter int QDEPTH_LOG2    = 2,
    parameter int CNT_W          = 32,
    parameter int TIMEOUT_CYCLES = 1048576,
    parameter int MIN_GAP        = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    mv_job_sched_if.slave          host,
    input  logic                   abort,
    output logic [QDEPTH_LOG2:0]   q_count,
    output logic                   ctrl_running,
    output logic [WIDTH_W-1:0]     ctrl_width,
    output logic [ITER_W-1:0]      ctrl_iteration,
    input  logic                   ctrl_finish,
    output logic                   busy
);
    localparam int DEPTH    = 1 << QDEPTH_LOG2;
    localparam int ENT_W    = WIDTH_W + ITER_W + TAG_W;
    localparam int CNT_BITS = QDEPTH_LOG2 + 1;
    localparam logic [CNT_BITS-1:0] FULL       = CNT_BITS'(DEPTH);
    localparam logic [CNT_W-1:0]    TIMEOUT    = CNT_W'(TIMEOUT_CYCLES);
    localparam bit                  TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [3:0]          GAP_LOAD   = 4'((MIN_GAP > 0) ? MIN_GAP - 1 : 0);

    typedef enum logic [1:0] {IDLE, RUN, REPORT, GAP} state_t;
    state_t state;

    logic [ENT_W-1:0]       mem [DEPTH];
    logic [QDEPTH_LOG2-1:0] wr_ptr;
    logic [QDEPTH_LOG2-1:0] rd_ptr;
    logic [CNT_BITS-1:0]    count;
    logic                   push;
    logic                   pop;
    logic                   loaded;
    logic [WIDTH_W-1:0]     cur_width;
    logic [ITER_W-1:0]      cur_iter;
    logic [TAG_W-1:0]       cur_tag;
    logic [CNT_W-1:0]       cycle_cnt;
    logic [CNT_W-1:0]       cnt_inc;
    logic [3:0]             gap_cnt;
    logic                   run_end;

    assign host.job_ready = (count != FULL) && !abort;
    assign push    = host.job_valid && host.job_ready;
    // An abort landing on the pop cycle wins: nothing leaves the queue.
    assign pop     = (state == IDLE) && !loaded && (count != '0) && !abort;
    assign cnt_inc = (&cycle_cnt) ? cycle_cnt : cycle_cnt + CNT_W'(1);
    assign run_end = ctrl_finish || abort || (TIMEOUT_EN && (cnt_inc == TIMEOUT));
    assign q_count = count;
    assign busy    = (state != IDLE) || (count != '0) || loaded;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {host.job_width, host.job_iter, host.job_tag};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (abort) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + QDEPTH_LOG2'(1);
            if (pop)  rd_ptr <= rd_ptr + QDEPTH_LOG2'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_BITS'(1);
                2'b01:   count <= count - CNT_BITS'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            loaded           <= 1'b0;
            cur_width        <= '0;
            cur_iter         <= '0;
            cur_tag          <= '0;
            ctrl_running     <= 1'b0;
            ctrl_width       <= '0;
            ctrl_iteration   <= '0;
            cycle_cnt        <= '0;
            gap_cnt          <= '0;
            host.done_valid  <= 1'b0;
            host.done_tag    <= '0;
            host.done_status <= 2'd0;
            host.done_bank   <= 1'b0;
            host.done_cycles <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        {cur_width, cur_iter, cur_tag} <= mem[rd_ptr];
                        loaded <= 1'b1;
                    end else if (loaded) begin
                        loaded <= 1'b0;
                        // A popped-but-unlaunched job is still queue content and dies with an abort.
                        if (!abort) begin
                            if ((cur_width == '0) || (cur_iter == '0)) begin
                                host.done_valid  <= 1'b1;
                                host.done_tag    <= cur_tag;
                                host.done_status <= 2'd3;
                                host.done_bank   <= cur_iter[0];
                                host.done_cycles <= '0;
                                state            <= REPORT;
                            end else begin
                                ctrl_width     <= cur_width;
                                ctrl_iteration <= cur_iter;
                                ctrl_running   <= 1'b1;
                                cycle_cnt      <= '0;
                                state          <= RUN;
                            end
                        end
                    end
                end
                RUN: begin
                    cycle_cnt <= cnt_inc;
                    if (run_end) begin
                        ctrl_running     <= 1'b0;
                        host.done_valid  <= 1'b1;
                        host.done_tag    <= cur_tag;
                        host.done_bank   <= cur_iter[0];
                        host.done_cycles <= cnt_inc;
                        host.done_status <= ctrl_finish ? 2'd0 : (abort ? 2'd2 : 2'd1);
                        state            <= REPORT;
                    end
                end
                REPORT: begin
                    if (host.done_ready) begin
                        host.done_valid <= 1'b0;
                        gap_cnt         <= GAP_LOAD;
                        state           <= (MIN_GAP > 0) ? GAP : IDLE;
                    end
                end
                GAP: begin
                    if (gap_cnt == 4'd0) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mv_job_sched.sv
// Directed and randomized bench for mv_job_sched with a behavioural Controller emulator
// and an ordered expected-record model.
module tb_mv_job_sched;
    localparam int WIDTH_W        = 9;
    localparam int ITER_W         = 16;
    localparam int TAG_W          = 4;
    localparam int QDEPTH_LOG2    = 2;
    localparam int CNT_W          = 32;
    localparam int TIMEOUT_CYCLES = 100;
    localparam int MIN_GAP        = 1;
    localparam int NRAND          = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic abort = 1'b0;
    logic ctrl_finish = 1'b0;
    logic ctrl_running;
    logic busy;
    logic [QDEPTH_LOG2:0] q_count;
    logic [WIDTH_W-1:0]   ctrl_width;
    logic [ITER_W-1:0]    ctrl_iteration;

    mv_job_sched_if #(.WIDTH_W(WIDTH_W), .ITER_W(ITER_W), .TAG_W(TAG_W), .CNT_W(CNT_W)) host();

    mv_job_sched #(
        .WIDTH_W(WIDTH_W), .ITER_W(ITER_W), .TAG_W(TAG_W), .QDEPTH_LOG2(QDEPTH_LOG2),
        .CNT_W(CNT_W), .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .MIN_GAP(MIN_GAP)
    ) dut (
        .clk(clk), .rst(rst), .host(host), .abort(abort), .q_count(q_count),
        .ctrl_running(ctrl_running), .ctrl_width(ctrl_width), .ctrl_iteration(ctrl_iteration),
        .ctrl_finish(ctrl_finish), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Controller emulator: each launch consumes the next expected launch, finish after fin cycles (0 = never).
    typedef struct { int w; int it; int fin; } launch_t;
    launch_t fin_q[$];
    launch_t emu_l;
    int run_cyc = 0;
    int low_cyc = 0;
    int cur_fin = 0;
    int hi_len  = 0;
    bit first   = 1'b1;

    always begin
        @(posedge clk);
        #1;
        if (rst) begin
            run_cyc = 0; low_cyc = 0; first = 1'b1; ctrl_finish = 1'b0;
        end else if (ctrl_running) begin
            if (run_cyc == 0) begin
                chk("launch_expected", fin_q.size() != 0, 1);
                if (!first) chk("low_gap", low_cyc >= MIN_GAP + 1, 1);
                if (fin_q.size() != 0) begin
                    emu_l = fin_q.pop_front();
                    chk("launch_width", ctrl_width, emu_l.w);
                    chk("launch_iter", ctrl_iteration, emu_l.it);
                    cur_fin = emu_l.fin;
                end else begin
                    cur_fin = 0;
                end
                first   = 1'b0;
                low_cyc = 0;
            end
            run_cyc++;
            ctrl_finish = (cur_fin != 0) && (run_cyc == cur_fin);
        end else begin
            if (run_cyc != 0) hi_len = run_cyc;
            run_cyc = 0;
            low_cyc++;
            ctrl_finish = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push_job(input int w, input int it, input int tag);
        int n = 0;
        while (!host.job_ready && n < 300) begin tick(); n++; end
        chk("push_ready", host.job_ready, 1);
        host.job_valid = 1'b1;
        host.job_width = WIDTH_W'(w);
        host.job_iter  = ITER_W'(it);
        host.job_tag   = TAG_W'(tag);
        tick();
        host.job_valid = 1'b0;
    endtask

    task automatic wait_running(input int bound);
        int n = 0;
        while (!ctrl_running && n < bound) begin tick(); n++; end
        chk("run_start", ctrl_running, 1);
    endtask

    task automatic collect(input int tag, input int status, input int bank, input int cycles, input int bound);
        int n = 0;
        while (!host.done_valid && n < bound) begin tick(); n++; end
        chk("done_seen", host.done_valid, 1);
        chk("done_tag", host.done_tag, tag);
        chk("done_status", host.done_status, status);
        chk("done_bank", host.done_bank, bank);
        chk("done_cycles", host.done_cycles, cycles);
        host.done_ready = 1'b1;
        tick();
        host.done_ready = 1'b0;
        chk("done_drop", host.done_valid, 0);
    endtask

    int its[4] = '{3, 2, 1, 4};
    int rw[NRAND];
    int ri[NRAND];
    int rf[NRAND];

    initial begin
        host.job_valid = 1'b0; host.job_width = '0; host.job_iter = '0; host.job_tag = '0;
        host.done_ready = 1'b0;
        #12;
        chk("rst_job_ready", host.job_ready, 1);
        chk("rst_q_count", q_count, 0);
        chk("rst_running", ctrl_running, 0);
        chk("rst_done_valid", host.done_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done_cycles", host.done_cycles, 0);
        chk("rst_done_tag", host.done_tag, 0);
        chk("rst_ctrl_width", ctrl_width, 0);
        rst = 1'b0;
        tick();

        // single job, launch latency and 40-cycle run
        fin_q.push_back('{17, 3, 40});
        push_job(17, 3, 1);
        chk("t1_lat_n", ctrl_running, 0);
        tick();
        chk("t1_lat_n1", ctrl_running, 0);
        tick();
        chk("t1_lat_n2", ctrl_running, 1);
        chk("t1_busy", busy, 1);
        collect(1, 0, 1, 40, 100);
        chk("t1_hi_len", hi_len, 40);

        // fill the queue behind a long job
        fin_q.push_back('{24, 5, 60});
        push_job(24, 5, 2);
        wait_running(10);
        for (int j = 0; j < 4; j++) begin
            fin_q.push_back('{24, its[j], 5});
            push_job(24, its[j], 3 + j);
        end
        chk("t2_q_full", q_count, 4);
        chk("t2_ready_low", host.job_ready, 0);
        collect(2, 0, 1, 60, 200);
        for (int j = 0; j < 4; j++) begin
            wait_running(20);
            chk("t2_q_step", q_count, 3 - j);
            collect(3 + j, 0, its[j] & 1, 5, 50);
        end

        // zero width is rejected without launching
        push_job(0, 5, 7);
        collect(7, 3, 1, 0, 3);
        chk("t3_running", ctrl_running, 0);

        // timeout
        fin_q.push_back('{9, 2, 0});
        push_job(9, 2, 8);
        collect(8, 1, 0, TIMEOUT_CYCLES, 300);
        chk("t4_hi_len", hi_len, TIMEOUT_CYCLES);

        // abort mid-run flushes the second job
        fin_q.push_back('{10, 1, 0});
        push_job(10, 1, 9);
        push_job(11, 1, 10);
        wait_running(10);
        chk("t5_q_before", q_count, 1);
        repeat (5) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t5_run_drop", ctrl_running, 0);
        chk("t5_q_flushed", q_count, 0);
        collect(9, 2, 1, 6, 5);
        repeat (10) tick();
        chk("t5_no_launch", ctrl_running, 0);
        chk("t5_idle", busy, 0);

        // abort coinciding with finish: finish wins, queue still flushed
        fin_q.push_back('{12, 2, 8});
        push_job(12, 2, 11);
        push_job(13, 3, 12);
        wait_running(10);
        repeat (7) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t5b_run_drop", ctrl_running, 0);
        chk("t5b_q_flushed", q_count, 0);
        collect(11, 0, 0, 8, 5);
        repeat (10) tick();
        chk("t5b_idle", busy, 0);

        // randomized jobs against the ordered record model
        for (int i = 0; i < NRAND; i++) begin
            rw[i] = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 511));
            ri[i] = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 65535));
            rf[i] = int'($urandom_range(1, 30));
            if (rw[i] != 0 && ri[i] != 0) fin_q.push_back('{rw[i], ri[i], rf[i]});
        end
        fork
            begin
                for (int i = 0; i < NRAND; i++) begin
                    repeat ($urandom_range(0, 3)) tick();
                    push_job(rw[i], ri[i], i);
                end
            end
            begin
                for (int k = 0; k < NRAND; k++) begin
                    repeat ($urandom_range(0, 4)) tick();
                    if (rw[k] != 0 && ri[k] != 0) collect(k, 0, ri[k] & 1, rf[k], 500);
                    else collect(k, 3, ri[k] & 1, 0, 500);
                end
            end
        join
        chk("rand_all_launched", fin_q.size(), 0);

        // stalled record stays stable and blocks launches; then reset mid-run
        fin_q.push_back('{14, 3, 3});
        push_job(14, 3, 13);
        fin_q.push_back('{15, 4, 0});
        push_job(15, 4, 14);
        begin
            int n = 0;
            while (!host.done_valid && n < 30) begin tick(); n++; end
        end
        repeat (20) begin
            chk("t6_hold_valid", host.done_valid, 1);
            chk("t6_hold_tag", host.done_tag, 13);
            chk("t6_hold_cycles", host.done_cycles, 3);
            chk("t6_hold_norun", ctrl_running, 0);
            chk("t6_hold_q", q_count, 1);
            tick();
        end
        collect(13, 0, 1, 3, 2);
        wait_running(10);
        push_job(1, 1, 15);
        tick();
        tick();
        chk("t6_q_before_rst", q_count, 1);
        #3;
        rst = 1'b1;
        #1;
        chk("t6_rst_running", ctrl_running, 0);
        chk("t6_rst_done_valid", host.done_valid, 0);
        chk("t6_rst_q", q_count, 0);
        chk("t6_rst_busy", busy, 0);
        tick();
        tick();
        rst = 1'b0;
        chk("t6_ready_after", host.job_ready, 1);
        repeat (8) tick();
        chk("t6_no_relaunch", ctrl_running, 0);
        chk("t6_no_record", host.done_valid, 0);
        chk("t6_fin_q_empty", fin_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
